uart_ack_link: RTL and testbench
================================

Name: uart_ack_link

Overview:
- Parametrised full-duplex UART link endpoint for board-to-board external communication.
- Outbound: carries multi-byte words, each acknowledged by the far end; a word is retransmitted on timeout or bad ACK, with a bounded number of retries.
- Inbound: assembles multi-byte words and returns an ACK byte for each complete word.
- Uses two serial pairs, mapped to GPIO: data_tx/ack_rx for outbound, data_rx/ack_tx for inbound.

Parameters:
- UART_WIDTH, 8, data bits per UART frame.
- WORD_BYTES, 2, frames per word; word width W = UART_WIDTH*WORD_BYTES.
- CLK_FREQ, 50_000_000, clock frequency in Hz.
- UART_BAUD_RATE, 230400, bit rate.
- UART_RETRANSMIT_COUNT, 5, retries after the first attempt.
- ACK_TIMEOUT_BAUDS, 64, bit periods allowed for an ACK, and the maximum inter-byte gap inside an inbound word.
- ACK_BYTE, 8'hCC, acknowledge value; width is UART_WIDTH.

Ports:
- clk  in  1  system clock
- rstN  in  1  reset
- tx_data  in  W  outbound word
- tx_valid  in  1  outbound word valid
- tx_ready  out  1  outbound FSM idle, word accepted when tx_valid&tx_ready
- tx_done  out  1  1-cycle pulse: word acknowledged
- tx_fail  out  1  1-cycle pulse: retries exhausted
- attempt_cnt  out  $clog2(UART_RETRANSMIT_COUNT+2)  attempts used for the current/last word
- rx_data  out  W  last complete inbound word
- rx_valid  out  1  1-cycle pulse: rx_data updated
- data_tx  out  1  outbound serial data
- ack_rx  in  1  serial ACK from far end
- data_rx  in  1  inbound serial data
- ack_tx  out  1  serial ACK to far end
- Interface (already decided): one clock; reset is synchronous and active-low.

Behaviour:
- Reset values: data_tx=1, ack_tx=1, tx_ready=1, tx_done=0, tx_fail=0, rx_valid=0, rx_data=0, attempt_cnt=0. All counters clear.
- Reset mid-frame: the serial lines are driven high from the next clock edge.
- Bit period: BIT_CYC = CLK_FREQ/UART_BAUD_RATE, integer-truncated (217 at defaults).
- Frame format: 1 start bit (0), UART_WIDTH data bits LSB first, 1 stop bit (1). Each bit is held exactly BIT_CYC cycles.
- Transmitters: the line idles high. Two independent serializers, one for data_tx and one for ack_tx.
- Receivers (data_rx, ack_rx):
  - 2-FF synchronizer, then falling-edge detect.
  - Line re-checked at BIT_CYC/2; if it is high, abort (glitch) and return to hunt.
  - Each bit sampled at mid-bit.
  - Stop bit sampled as 0 gives a framing error: byte dropped.
  - Receiver re-arms for the next start bit at mid-stop-bit.
- Outbound FSM: IDLE -> SEND -> WAIT_ACK -> (IDLE | SEND).
  - IDLE: tx_ready=1. On tx_valid, latch the word, set attempt_cnt=1, go to SEND.
  - SEND: transmit bytes, least-significant byte first, back-to-back with no idle gap. After the last stop bit, go to WAIT_ACK with the timeout counter cleared.
  - WAIT_ACK, byte == ACK_BYTE received: tx_done pulses, go to IDLE.
  - WAIT_ACK, any other byte received, or ACK_TIMEOUT_BAUDS*BIT_CYC cycles elapse: NACK.
  - On NACK: if attempt_cnt <= UART_RETRANSMIT_COUNT, increment attempt_cnt and go to SEND with the latched word. Otherwise tx_fail pulses and go to IDLE.
  - Total attempts are at most UART_RETRANSMIT_COUNT+1.
  - Bytes arriving on ack_rx outside WAIT_ACK are discarded.
  - tx_valid while busy is ignored (tx_ready=0).
- Inbound path:
  - Bytes are assembled LSB-byte first into a shift buffer with a byte counter.
  - After WORD_BYTES bytes: rx_data is updated, rx_valid pulses on the same edge, and ACK_BYTE is queued on ack_tx. The ACK frame start bit begins within 2 cycles.
  - An inter-byte gap greater than ACK_TIMEOUT_BAUDS*BIT_CYC, measured from stop bit to next start bit, discards the partial word; no ACK is sent.
  - A framing-error byte discards the partial word.
  - If a word completes while a previous ACK is still being sent, the new ACK is sent immediately after it. Queue depth is 1; further overflow drops the ACK but rx_valid still pulses.
- The inbound and outbound paths operate fully concurrently.

Optional Feature:
- Macro: UART_PARITY_EN.
- Defined: an even-parity bit follows the data bits in every frame, in both directions and for ACK frames.
  - A parity error on data_rx discards the partial word, so no ACK is sent.
  - A parity error on ack_rx counts as a NACK.
- Undefined: no parity bit; frame length is UART_WIDTH+2 bits.

Test Plan:
- Outbound ACK: tx_data=16'hA55A, tx_valid for 1 cycle -> data_tx frames 0x5A then 0xA5, 217 cycles/bit. Bench replies 0xCC on ack_rx after 20 bit periods -> tx_done pulse, attempt_cnt=1, tx_ready=1.
- Retries exhausted: same word, ack_rx held high -> 6 identical transmissions, each separated by 64*217 cycles of silence. Then tx_fail pulses, attempt_cnt=6, and no further frames are sent.
- Bad ACK: bench sends 0x33 on the first attempt, then 0xCC on the second -> immediate retransmit after the 0x33 stop bit; tx_done pulses with attempt_cnt=2.
- Inbound word: bench sends 0x2A then 0x00 on data_rx -> rx_data=16'h002A, rx_valid pulses once, ack_tx emits frame 0xCC. Repeat with 0x3B, 0x00 -> 16'h003B.
- Partial word and glitch: bench sends 0x2A, then waits 100 bit periods -> no rx_valid, no ACK. A 1-cycle low glitch on data_rx produces no byte. A subsequent full word is received correctly.
- Reset mid-frame: rstN=0 for 1 cycle during the 0xA5 data bits -> data_tx=1 on the next edge, tx_ready=1, and no tx_done or tx_fail pulse ever follows.

Source files
------------

// File: rtl/uart_ack_link.sv
// Full-duplex UART link endpoint: acknowledged, retransmitted outbound words and
// ACK-returning inbound word assembly. Define UART_PARITY_EN to add an even-parity bit.
module uart_ack_link #(
    parameter int unsigned UART_WIDTH            = 8,
    parameter int unsigned WORD_BYTES            = 2,
    parameter int unsigned CLK_FREQ              = 50_000_000,
    parameter int unsigned UART_BAUD_RATE        = 230400,
    parameter int unsigned UART_RETRANSMIT_COUNT = 5,
    parameter int unsigned ACK_TIMEOUT_BAUDS     = 64,
    parameter logic [UART_WIDTH-1:0] ACK_BYTE    = 8'hCC,
    localparam int unsigned W  = UART_WIDTH * WORD_BYTES,
    localparam int unsigned AW = $clog2(UART_RETRANSMIT_COUNT + 2)
) (
    input  logic          clk,
    input  logic          rstN,
    input  logic [W-1:0]  tx_data,
    input  logic          tx_valid,
    output logic          tx_ready,
    output logic          tx_done,
    output logic          tx_fail,
    output logic [AW-1:0] attempt_cnt,
    output logic [W-1:0]  rx_data,
    output logic          rx_valid,
    output logic          data_tx,
    input  logic          ack_rx,
    input  logic          data_rx,
    output logic          ack_tx
);
    localparam int unsigned BIT_CYC = CLK_FREQ / UART_BAUD_RATE;
    localparam int unsigned HALF    = BIT_CYC / 2;
    localparam int unsigned TMO_CYC = ACK_TIMEOUT_BAUDS * BIT_CYC;
`ifdef UART_PARITY_EN
    localparam int unsigned PAR = 1;
`else
    localparam int unsigned PAR = 0;
`endif
    localparam int unsigned FB = UART_WIDTH + 2 + PAR;
    localparam int unsigned CW = $clog2(BIT_CYC);
    localparam int unsigned BW = $clog2(FB);
    localparam int unsigned TW = $clog2(TMO_CYC + 1);
    localparam int unsigned NW = $clog2(WORD_BYTES + 1);

    typedef enum logic [1:0] {StIdle, StSend, StWaitAck} ostate_e;

    function automatic logic [FB-1:0] frame(input logic [UART_WIDTH-1:0] b);
`ifdef UART_PARITY_EN
        return {1'b1, ^b, b, 1'b0};
`else
        return {1'b1, b, 1'b0};
`endif
    endfunction

    // Channel 0 is the data pair (data_tx/data_rx), channel 1 the ACK pair (ack_tx/ack_rx).
    logic [1:0]            ser_busy_q, ser_end, ser_start;
    logic [FB-1:0]         ser_sh_q  [2];
    logic [CW-1:0]         ser_cyc_q [2];
    logic [BW-1:0]         ser_bit_q [2];
    logic                  data_start, ack_start;
    logic [UART_WIDTH-1:0] data_byte;

    logic [1:0]            rx_line, rx_s1_q, rx_s2_q, rx_s3_q, rx_busy_q;
    logic [1:0]            rx_stb_q, rx_ferr_q, rx_perr_q, rx_pbad_q;
    logic [UART_WIDTH-1:0] rx_sh_q  [2];
    logic [CW-1:0]         rx_cyc_q [2];
    logic [BW-1:0]         rx_bit_q [2];

    assign ser_start = {ack_start, data_start};
    assign rx_line   = {ack_rx, data_rx};
    assign data_tx   = ser_sh_q[0][0];
    assign ack_tx    = ser_sh_q[1][0];

    always_comb begin
        for (int c = 0; c < 2; c++) begin
            ser_end[c] = ser_busy_q[c] && ser_cyc_q[c] == CW'(BIT_CYC - 1)
                         && ser_bit_q[c] == BW'(FB - 1);
        end
    end

    // Idle shifter holds all ones, so the line output is a plain register bit.
    always_ff @(posedge clk) begin
        for (int c = 0; c < 2; c++) begin
            if (!rstN) begin
                ser_busy_q[c] <= 1'b0;
                ser_sh_q[c]   <= '1;
                ser_cyc_q[c]  <= '0;
                ser_bit_q[c]  <= '0;
            end else if (ser_start[c]) begin
                ser_busy_q[c] <= 1'b1;
                ser_sh_q[c]   <= frame((c == 0) ? data_byte : ACK_BYTE);
                ser_cyc_q[c]  <= '0;
                ser_bit_q[c]  <= '0;
            end else if (ser_busy_q[c]) begin
                if (ser_cyc_q[c] == CW'(BIT_CYC - 1)) begin
                    ser_cyc_q[c] <= '0;
                    ser_sh_q[c]  <= {1'b1, ser_sh_q[c][FB-1:1]};
                    if (ser_bit_q[c] == BW'(FB - 1)) ser_busy_q[c] <= 1'b0;
                    else ser_bit_q[c] <= ser_bit_q[c] + BW'(1);
                end else begin
                    ser_cyc_q[c] <= ser_cyc_q[c] + CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int c = 0; c < 2; c++) begin
            if (!rstN) begin
                {rx_s1_q[c], rx_s2_q[c], rx_s3_q[c]} <= 3'b111;
                {rx_busy_q[c], rx_stb_q[c], rx_ferr_q[c], rx_perr_q[c]} <= 4'b0000;
                rx_pbad_q[c] <= 1'b0;
                rx_sh_q[c]   <= '0;
                rx_cyc_q[c]  <= '0;
                rx_bit_q[c]  <= '0;
            end else begin
                rx_s1_q[c]   <= rx_line[c];
                rx_s2_q[c]   <= rx_s1_q[c];
                rx_s3_q[c]   <= rx_s2_q[c];
                rx_stb_q[c]  <= 1'b0;
                rx_ferr_q[c] <= 1'b0;
                rx_perr_q[c] <= 1'b0;
                if (!rx_busy_q[c]) begin
                    if (rx_s3_q[c] && !rx_s2_q[c]) begin
                        rx_busy_q[c] <= 1'b1;
                        rx_cyc_q[c]  <= '0;
                        rx_bit_q[c]  <= '0;
                    end
                end else if (rx_cyc_q[c] == ((rx_bit_q[c] == '0) ? CW'(HALF - 1)
                                                                 : CW'(BIT_CYC - 1))) begin
                    rx_cyc_q[c] <= '0;
                    rx_bit_q[c] <= rx_bit_q[c] + BW'(1);
                    if (rx_bit_q[c] == '0) begin
                        if (rx_s2_q[c]) rx_busy_q[c] <= 1'b0;
                    end else if (rx_bit_q[c] <= BW'(UART_WIDTH)) begin
                        rx_sh_q[c] <= {rx_s2_q[c], rx_sh_q[c][UART_WIDTH-1:1]};
`ifdef UART_PARITY_EN
                    end else if (rx_bit_q[c] == BW'(UART_WIDTH + 1)) begin
                        rx_pbad_q[c] <= rx_s2_q[c] ^ (^rx_sh_q[c]);
`endif
                    end else begin
                        // Mid-stop-bit: deliver the byte and re-arm for the next start bit.
                        rx_busy_q[c] <= 1'b0;
                        rx_pbad_q[c] <= 1'b0;
                        rx_stb_q[c]  <= rx_s2_q[c] & ~rx_pbad_q[c];
                        rx_perr_q[c] <= rx_s2_q[c] & rx_pbad_q[c];
                        rx_ferr_q[c] <= ~rx_s2_q[c];
                    end
                end else begin
                    rx_cyc_q[c] <= rx_cyc_q[c] + CW'(1);
                end
            end
        end
    end

    // Inbound word assembly and ACK queue (one frame in flight plus one pending).
    logic [W-1:0]  ibuf_q, ibuf_next;
    logic [NW-1:0] icnt_q;
    logic [TW-1:0] gap_q;
    logic          word_done, ack_pend_q, ack_pend_d;
    logic          unused_ferr;

    assign unused_ferr = rx_ferr_q[1];
    assign ibuf_next   = (ibuf_q >> UART_WIDTH) | (W'(rx_sh_q[0]) << (W - UART_WIDTH));
    assign word_done   = rx_stb_q[0] && icnt_q == NW'(WORD_BYTES - 1);
    assign ack_start   = ack_pend_q && (!ser_busy_q[1] || ser_end[1]);

    always_comb begin
        ack_pend_d = ack_pend_q;
        if (ack_start) ack_pend_d = 1'b0;
        if (word_done && (!ack_pend_q || ack_start)) ack_pend_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rstN) begin
            ibuf_q     <= '0;
            icnt_q     <= '0;
            gap_q      <= '0;
            ack_pend_q <= 1'b0;
            rx_data    <= '0;
            rx_valid   <= 1'b0;
        end else begin
            ack_pend_q <= ack_pend_d;
            rx_valid   <= 1'b0;
            if (rx_stb_q[0]) begin
                gap_q  <= '0;
                ibuf_q <= ibuf_next;
                if (word_done) begin
                    rx_data  <= ibuf_next;
                    rx_valid <= 1'b1;
                    icnt_q   <= '0;
                end else begin
                    icnt_q <= icnt_q + NW'(1);
                end
            end else if (rx_ferr_q[0] || rx_perr_q[0]) begin
                icnt_q <= '0;
                gap_q  <= '0;
            end else if (icnt_q == '0 || rx_busy_q[0]) begin
                gap_q <= '0;
            end else if (gap_q == TW'(TMO_CYC)) begin
                icnt_q <= '0;
                gap_q  <= '0;
            end else begin
                gap_q <= gap_q + TW'(1);
            end
        end
    end

    // Outbound FSM.
    ostate_e       ost_q, ost_d;
    logic [W-1:0]  oword_q;
    logic [NW-1:0] obyte_q;
    logic [TW-1:0] tmo_q;
    logic [AW-1:0] att_q;
    logic          ack_ok, nack, retry;

    assign ack_ok      = rx_stb_q[1] && rx_sh_q[1] == ACK_BYTE;
    assign nack        = (rx_stb_q[1] && rx_sh_q[1] != ACK_BYTE) || rx_perr_q[1]
                         || tmo_q == TW'(TMO_CYC - 1);
    assign retry       = att_q <= AW'(UART_RETRANSMIT_COUNT);
    assign attempt_cnt = att_q;

    always_ff @(posedge clk) begin
        if (!rstN) ost_q <= StIdle;
        else ost_q <= ost_d;
    end

    always_comb begin
        ost_d = ost_q;
        unique case (ost_q)
            StIdle:    if (tx_valid) ost_d = StSend;
            StSend:    if (ser_end[0] && obyte_q == NW'(WORD_BYTES)) ost_d = StWaitAck;
            StWaitAck: begin
                if (ack_ok) ost_d = StIdle;
                else if (nack) ost_d = retry ? StSend : StIdle;
            end
            default:   ost_d = StIdle;
        endcase
    end

    always_comb begin
        tx_ready   = ost_q == StIdle;
        data_start = ost_q == StSend && obyte_q != NW'(WORD_BYTES)
                     && (!ser_busy_q[0] || ser_end[0]);
        data_byte  = UART_WIDTH'(oword_q >> (UART_WIDTH * obyte_q));
    end

    always_ff @(posedge clk) begin
        if (!rstN) begin
            oword_q <= '0;
            obyte_q <= '0;
            tmo_q   <= '0;
            att_q   <= '0;
            tx_done <= 1'b0;
            tx_fail <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            tx_fail <= 1'b0;
            if (ost_q == StIdle && tx_valid) begin
                oword_q <= tx_data;
                att_q   <= AW'(1);
                obyte_q <= '0;
            end
            if (data_start) obyte_q <= obyte_q + NW'(1);
            if (ost_q == StWaitAck) begin
                tmo_q <= tmo_q + TW'(1);
                if (ack_ok) begin
                    tx_done <= 1'b1;
                end else if (nack) begin
                    if (retry) begin
                        att_q   <= att_q + AW'(1);
                        obyte_q <= '0;
                    end else begin
                        tx_fail <= 1'b1;
                    end
                end
            end else begin
                tmo_q <= '0;
            end
        end
    end
endmodule

// File: tb/tb_uart_ack_link.sv
// Directed bench for uart_ack_link; a 3.7 MHz clock at 230400 baud truncates to
// 16 cycles per bit so the retry scenario stays short.
module tb_uart_ack_link;
    localparam int unsigned CLK_FREQ = 3_700_000;
    localparam int unsigned BAUD     = 230400;
    localparam int BIT  = 16;
    localparam int HALF = 8;
    localparam int TMO  = 64 * BIT;

    logic        clk = 1'b0;
    logic        rstN, tx_valid, tx_ready, tx_done, tx_fail, rx_valid;
    logic        data_tx, ack_rx, data_rx, ack_tx;
    logic [15:0] tx_data, rx_data;
    logic [2:0]  attempt_cnt;

    int tests = 0, fails = 0, cyc = 0;
    int done_cnt = 0, fail_cnt = 0, rxv_cnt = 0, rxv_t = 0, t_send = 0;
    logic watch = 1'b0, low_seen = 1'b0;
    logic [7:0] dq[$], aq[$];
    int         dt[$], at[$];

    uart_ack_link #(
        .UART_WIDTH(8), .WORD_BYTES(2), .CLK_FREQ(CLK_FREQ), .UART_BAUD_RATE(BAUD),
        .UART_RETRANSMIT_COUNT(5), .ACK_TIMEOUT_BAUDS(64), .ACK_BYTE(8'hCC)
    ) dut (
        .clk(clk), .rstN(rstN), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .tx_done(tx_done), .tx_fail(tx_fail),
        .attempt_cnt(attempt_cnt), .rx_data(rx_data), .rx_valid(rx_valid),
        .data_tx(data_tx), .ack_rx(ack_rx), .data_rx(data_rx), .ack_tx(ack_tx)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (tx_done === 1'b1) done_cnt <= done_cnt + 1;
        if (tx_fail === 1'b1) fail_cnt <= fail_cnt + 1;
        if (rx_valid === 1'b1) begin
            rxv_cnt <= rxv_cnt + 1;
            rxv_t   <= cyc;
        end
        if (watch && data_tx === 1'b0) low_seen <= 1'b1;
    end

    function automatic logic line_of(input int ch);
        return (ch == 0) ? data_tx : ack_tx;
    endfunction

    // Decode one frame from a DUT output line; frames with a bad start or stop are not logged.
    task automatic mon_frame(input int ch);
        logic [7:0] b;
        int t0;
        @(negedge clk);
        t0 = cyc;
        repeat (HALF) @(negedge clk);
        if (line_of(ch) !== 1'b0) return;
        for (int i = 0; i < 8; i++) begin
            repeat (BIT) @(negedge clk);
            b[i] = line_of(ch);
        end
        repeat (BIT) @(negedge clk);
        if (line_of(ch) !== 1'b1) return;
        if (ch == 0) begin dq.push_back(b); dt.push_back(t0); end
        else begin aq.push_back(b); at.push_back(t0); end
    endtask

    initial forever begin @(negedge data_tx); mon_frame(0); end
    initial forever begin @(negedge ack_tx);  mon_frame(1); end

    initial begin
        repeat (90000) @(posedge clk);
        $display("FAIL watchdog: run reached %0d cycles, required to finish earlier", cyc);
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_line(input int ch, input logic v);
        if (ch == 0) data_rx = v;
        else ack_rx = v;
    endtask

    task automatic send_frame(input int ch, input logic [7:0] b);
        t_send = cyc;
        set_line(ch, 1'b0);
        repeat (BIT) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            set_line(ch, b[i]);
            repeat (BIT) @(negedge clk);
        end
        set_line(ch, 1'b1);
        repeat (BIT) @(negedge clk);
    endtask

    task automatic issue(input logic [15:0] w);
        tx_data  = w;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    task automatic wait_dq(input int n, input int budget, input string tag);
        int k = 0;
        while (dq.size() < n && k < budget) begin @(negedge clk); k++; end
        chk(tag, 32'(dq.size() >= n), 32'd1);
    endtask

    task automatic wait_aq(input int n, input int budget, input string tag);
        int k = 0;
        while (aq.size() < n && k < budget) begin @(negedge clk); k++; end
        chk(tag, 32'(aq.size() >= n), 32'd1);
    endtask

    int n0, d0, f0, r0, a0, k;

    initial begin
        rstN = 1'b0; tx_valid = 1'b0; tx_data = '0; data_rx = 1'b1; ack_rx = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_data_tx", 32'(data_tx), 32'd1);
        chk("rst_ack_tx", 32'(ack_tx), 32'd1);
        chk("rst_tx_ready", 32'(tx_ready), 32'd1);
        chk("rst_tx_done", 32'(tx_done), 32'd0);
        chk("rst_tx_fail", 32'(tx_fail), 32'd0);
        chk("rst_rx_valid", 32'(rx_valid), 32'd0);
        chk("rst_rx_data", 32'(rx_data), 32'd0);
        chk("rst_attempt", 32'(attempt_cnt), 32'd0);
        rstN = 1'b1;
        repeat (4) @(negedge clk);

        // Outbound word acknowledged on the first attempt.
        n0 = dq.size(); d0 = done_cnt; f0 = fail_cnt;
        issue(16'hA55A);
        chk("busy_after_accept", 32'(tx_ready), 32'd0);
        chk("attempt_first", 32'(attempt_cnt), 32'd1);
        wait_dq(n0 + 2, 40 * BIT, "ack_two_frames");
        if (dq.size() >= n0 + 2) begin
            chk("ack_byte_lo", 32'(dq[n0]), 32'h5A);
            chk("ack_byte_hi", 32'(dq[n0+1]), 32'hA5);
            chk("frame_spacing", 32'(dt[n0+1] - dt[n0]), 32'(10 * BIT));
        end
        repeat (20 * BIT) @(negedge clk);
        send_frame(1, 8'hCC);
        repeat (4) @(negedge clk);
        chk("ack_done", 32'(done_cnt - d0), 32'd1);
        chk("ack_no_fail", 32'(fail_cnt - f0), 32'd0);
        chk("ack_attempt", 32'(attempt_cnt), 32'd1);
        chk("ack_ready", 32'(tx_ready), 32'd1);

        // Bad ACK, then good ACK on the retransmission.
        n0 = dq.size(); d0 = done_cnt;
        issue(16'hA55A);
        wait_dq(n0 + 2, 40 * BIT, "bad_first_frames");
        repeat (5 * BIT) @(negedge clk);
        a0 = t_send;
        send_frame(1, 8'h33);
        a0 = t_send;
        wait_dq(n0 + 4, 40 * BIT, "bad_retx_frames");
        if (dq.size() >= n0 + 4) begin
            chk("bad_retx_lo", 32'(dq[n0+2]), 32'h5A);
            chk("bad_retx_hi", 32'(dq[n0+3]), 32'hA5);
            k = dt[n0+2] - a0;
            chk("bad_retx_latency", 32'(k >= 9 * BIT + HALF && k <= 10 * BIT), 32'd1);
        end
        repeat (5 * BIT) @(negedge clk);
        send_frame(1, 8'hCC);
        repeat (4) @(negedge clk);
        chk("bad_done", 32'(done_cnt - d0), 32'd1);
        chk("bad_attempt", 32'(attempt_cnt), 32'd2);

        // No ACK at all: six attempts, then a failure pulse.
        n0 = dq.size(); d0 = done_cnt; f0 = fail_cnt;
        issue(16'hA55A);
        k = 0;
        while (fail_cnt == f0 && k < 12000) begin @(negedge clk); k++; end
        chk("retry_fail_seen", 32'(fail_cnt - f0), 32'd1);
        chk("retry_attempt", 32'(attempt_cnt), 32'd6);
        repeat (2 * TMO) @(negedge clk);
        chk("retry_frames", 32'(dq.size() - n0), 32'd12);
        chk("retry_single_fail", 32'(fail_cnt - f0), 32'd1);
        chk("retry_no_done", 32'(done_cnt - d0), 32'd0);
        for (int i = 0; i + 1 < dq.size() - n0; i += 2) begin
            chk("retry_lo", 32'(dq[n0+i]), 32'h5A);
            chk("retry_hi", 32'(dq[n0+i+1]), 32'hA5);
        end
        if (dq.size() >= n0 + 3) begin
            k = dt[n0+2] - dt[n0];
            chk("retry_period", 32'(k >= 20 * BIT + TMO && k <= 20 * BIT + TMO + 3), 32'd1);
        end

        // Inbound words with ACK return.
        r0 = rxv_cnt; a0 = aq.size();
        send_frame(0, 8'h2A);
        send_frame(0, 8'h00);
        repeat (4) @(negedge clk);
        chk("in1_valid", 32'(rxv_cnt - r0), 32'd1);
        chk("in1_data", 32'(rx_data), 32'h002A);
        wait_aq(a0 + 1, 20 * BIT, "in1_ack_seen");
        if (aq.size() >= a0 + 1) begin
            chk("in1_ack_byte", 32'(aq[a0]), 32'hCC);
            chk("in1_ack_latency", 32'(at[a0] - rxv_t >= 0 && at[a0] - rxv_t <= 2), 32'd1);
        end
        r0 = rxv_cnt; a0 = aq.size();
        send_frame(0, 8'h3B);
        send_frame(0, 8'h00);
        repeat (4) @(negedge clk);
        chk("in2_valid", 32'(rxv_cnt - r0), 32'd1);
        chk("in2_data", 32'(rx_data), 32'h003B);
        wait_aq(a0 + 1, 20 * BIT, "in2_ack_seen");
        if (aq.size() >= a0 + 1) chk("in2_ack_byte", 32'(aq[a0]), 32'hCC);
        repeat (4 * BIT) @(negedge clk);

        // Stale partial word and a one-cycle glitch, then a clean word.
        r0 = rxv_cnt; a0 = aq.size();
        send_frame(0, 8'h2A);
        repeat (100 * BIT) @(negedge clk);
        data_rx = 1'b0;
        @(negedge clk);
        data_rx = 1'b1;
        repeat (4 * BIT) @(negedge clk);
        chk("partial_no_valid", 32'(rxv_cnt - r0), 32'd0);
        chk("partial_no_ack", 32'(aq.size() - a0), 32'd0);
        send_frame(0, 8'h11);
        send_frame(0, 8'h22);
        repeat (4) @(negedge clk);
        chk("after_partial_valid", 32'(rxv_cnt - r0), 32'd1);
        chk("after_partial_data", 32'(rx_data), 32'h2211);
        repeat (14 * BIT) @(negedge clk);

        // Reset during the data bits of the second byte.
        n0 = dq.size(); d0 = done_cnt; f0 = fail_cnt;
        issue(16'hA55A);
        wait_dq(n0 + 1, 20 * BIT, "mid_first_frame");
        repeat (3 * BIT) @(negedge clk);
        rstN = 1'b0;
        @(negedge clk);
        rstN = 1'b1;
        chk("mid_data_tx_high", 32'(data_tx), 32'd1);
        chk("mid_ready", 32'(tx_ready), 32'd1);
        chk("mid_attempt", 32'(attempt_cnt), 32'd0);
        watch = 1'b1;
        repeat (2 * TMO) @(negedge clk);
        chk("mid_line_quiet", 32'(low_seen), 32'd0);
        chk("mid_no_done", 32'(done_cnt - d0), 32'd0);
        chk("mid_no_fail", 32'(fail_cnt - f0), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
